// File: rtl/boid_accel.sv
// Single-boid physics update engine in signed fix15 (17.15, 1.0 = 0x8000).
// Each frame: steer away from screen edges, estimate speed with
// alpha-max-beta-min, clamp speed to [MIN_SPEED, MAX_SPEED] through a
// sequential restoring divider, then integrate position.
module boid_accel #(
  parameter logic [31:0] INIT_X        = 32'h00A0_0000,
  parameter logic [31:0] INIT_Y        = 32'h0078_0000,
  parameter logic [31:0] INIT_VX       = 32'h0000_8000,
  parameter logic [31:0] INIT_VY       = 32'h0000_4000,
  parameter logic [31:0] TURN_FACTOR   = 32'h0000_1999,
  parameter logic [31:0] MAX_SPEED     = 32'h0003_0000,
  parameter logic [31:0] MIN_SPEED     = 32'h0001_8000,
  parameter logic [31:0] LEFT_MARGIN   = 32'h0032_0000,
  parameter logic [31:0] RIGHT_MARGIN  = 32'h010E_0000,
  parameter logic [31:0] TOP_MARGIN    = 32'h0032_0000,
  parameter logic [31:0] BOTTOM_MARGIN = 32'h00BE_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] x,
  output logic [31:0] y,
  output logic [31:0] vx,
  output logic [31:0] vy,
  output logic [31:0] px,
  output logic [31:0] py
);

  typedef enum logic [2:0] {
    StEdge,
    StSpeed,
    StDiv,
    StScale,
    StMove
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic [31:0] vx_q, vx_d;
  logic [31:0] vy_q, vy_d;
  // Divider: partial remainder, dividend bits shifting out / quotient bits
  // shifting in, divisor (the speed estimate) and iteration counter.
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;

  // Speed estimate and its building blocks.
  logic [31:0] abs_vx, abs_vy, spd_hi, spd_lo, speed;
  // Edge-steering velocity candidates.
  logic [31:0] vx_turn, vy_turn;
  // Divider step.
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] rem_next;
  // Velocity scaling.
  logic signed [63:0] vx_ext, vy_ext, fac_ext, prod_x, prod_y;
  logic [31:0] vx_scaled, vy_scaled;

  assign x  = x_q;
  assign y  = y_q;
  assign vx = vx_q;
  assign vy = vy_q;
  assign px = {{15{x_q[31]}}, x_q[31:15]};
  assign py = {{15{y_q[31]}}, y_q[31:15]};

  // Shared combinational datapath: steering, speed estimate, divider step, scaling.
  always_comb begin
    vx_turn = vx_q;
    if ($signed(x_q) < $signed(LEFT_MARGIN))  vx_turn = vx_turn + TURN_FACTOR;
    if ($signed(x_q) > $signed(RIGHT_MARGIN)) vx_turn = vx_turn - TURN_FACTOR;
    vy_turn = vy_q;
    if ($signed(y_q) < $signed(TOP_MARGIN))    vy_turn = vy_turn + TURN_FACTOR;
    if ($signed(y_q) > $signed(BOTTOM_MARGIN)) vy_turn = vy_turn - TURN_FACTOR;

    // 0x80000000 negates to itself and is then read as unsigned 2^31.
    abs_vx = vx_q[31] ? (~vx_q + 32'd1) : vx_q;
    abs_vy = vy_q[31] ? (~vy_q + 32'd1) : vy_q;
    spd_hi = (abs_vx > abs_vy) ? abs_vx : abs_vy;
    spd_lo = (abs_vx > abs_vy) ? abs_vy : abs_vx;
    speed  = spd_hi + (spd_lo >> 1);

    div_shift = {rem_q, quo_q[31]};
    div_ge    = (div_shift >= {1'b0, dvs_q});
    rem_next  = div_ge ? 32'(div_shift - {1'b0, dvs_q}) : div_shift[31:0];

    vx_ext    = {{32{vx_q[31]}}, vx_q};
    vy_ext    = {{32{vy_q[31]}}, vy_q};
    fac_ext   = {{32{quo_q[31]}}, quo_q};
    prod_x    = vx_ext * fac_ext;
    prod_y    = vy_ext * fac_ext;
    vx_scaled = 32'(prod_x >>> 15);
    vy_scaled = 32'(prod_y >>> 15);
  end

  // Next-state logic for the update sequence.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    case (state_q)
      StEdge: begin
        vx_d    = vx_turn;
        vy_d    = vy_turn;
        state_d = StSpeed;
      end
      StSpeed: begin
        if (speed == 32'd0) begin
          vx_d    = MIN_SPEED;
          vy_d    = 32'd0;
          state_d = StMove;
        end else if (speed > MAX_SPEED || speed < MIN_SPEED) begin
          // Numerator is dividend << 15; its bits above 31 preload the
          // remainder and the low 32 bits shift in one per iteration.
          rem_d   = (speed > MAX_SPEED) ? (MAX_SPEED >> 17) : (MIN_SPEED >> 17);
          quo_d   = (speed > MAX_SPEED) ? (MAX_SPEED << 15) : (MIN_SPEED << 15);
          dvs_d   = speed;
          cnt_d   = 5'd0;
          state_d = StDiv;
        end else begin
          state_d = StMove;
        end
      end
      StDiv: begin
        rem_d = rem_next;
        quo_d = {quo_q[30:0], div_ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StScale;
      end
      StScale: begin
        vx_d    = vx_scaled;
        vy_d    = vy_scaled;
        state_d = StMove;
      end
      StMove: begin
        x_d     = x_q + vx_q;
        y_d     = y_q + vy_q;
        state_d = StEdge;
      end
      default: state_d = StEdge;
    endcase
  end

  // State registers: reset wins, otherwise advance only on enabled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEdge;
      x_q     <= INIT_X;
      y_q     <= INIT_Y;
      vx_q    <= INIT_VX;
      vy_q    <= INIT_VY;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      cnt_q   <= 5'd0;
    end else if (en) begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_boid_accel.sv
// Bench for boid_accel: four instances (defaults, edge turn, max clamp,
// zero speed) share clk/reset/en. A frame-level reference model predicts
// each full update and its length in enabled cycles.
module tb_boid_accel;

  localparam logic [31:0] TURN   = 32'h0000_1999;
  localparam logic [31:0] MAXS   = 32'h0003_0000;
  localparam logic [31:0] MINS   = 32'h0001_8000;
  localparam logic [31:0] LEFT   = 32'h0032_0000;
  localparam logic [31:0] RIGHT  = 32'h010E_0000;
  localparam logic [31:0] TOP    = 32'h0032_0000;
  localparam logic [31:0] BOTTOM = 32'h00BE_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ox[4], oy[4], ovx[4], ovy[4], opx[4], opy[4];

  boid_accel u_dut0 (
    .clk(clk), .reset(reset), .en(en), .x(ox[0]), .y(oy[0]), .vx(ovx[0]), .vy(ovy[0]),
    .px(opx[0]), .py(opy[0])
  );
  boid_accel #(.INIT_X(32'h0019_0000), .INIT_VX(32'h0002_0000), .INIT_VY(32'h0)) u_dut1 (
    .clk(clk), .reset(reset), .en(en), .x(ox[1]), .y(oy[1]), .vx(ovx[1]), .vy(ovy[1]),
    .px(opx[1]), .py(opy[1])
  );
  boid_accel #(.INIT_VX(32'h0004_0000), .INIT_VY(32'h0)) u_dut2 (
    .clk(clk), .reset(reset), .en(en), .x(ox[2]), .y(oy[2]), .vx(ovx[2]), .vy(ovy[2]),
    .px(opx[2]), .py(opy[2])
  );
  boid_accel #(.INIT_VX(32'h0), .INIT_VY(32'h0)) u_dut3 (
    .clk(clk), .reset(reset), .en(en), .x(ox[3]), .y(oy[3]), .vx(ovx[3]), .vy(ovy[3]),
    .px(opx[3]), .py(opy[3])
  );

  // Reference state per instance, plus the predicted result of the pending update.
  logic [31:0] ix[4], iy[4], ivx[4], ivy[4];
  logic [31:0] m_x[4], m_y[4], m_vx[4], m_vy[4];
  logic [31:0] n_x[4], n_y[4], n_vx[4], n_vy[4];
  int          m_len[4], m_cnt[4];
  int          n_chk = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fmul(input logic [31:0] v, input logic [31:0] f);
    longint p;
    p = longint'($signed(v)) * longint'($signed(f));
    return 32'(p >>> 15);
  endfunction

  // One full frame computed straight from the update rules.
  task automatic model_update(input logic [31:0] x, y, vx, vy,
                              output logic [31:0] nx, ny, nvx, nvy, output int len);
    logic [31:0] ax, ay, hi, lo, spd, dvd, f;
    nvx = vx;
    nvy = vy;
    if ($signed(x) < $signed(LEFT))   nvx += TURN;
    if ($signed(x) > $signed(RIGHT))  nvx -= TURN;
    if ($signed(y) < $signed(TOP))    nvy += TURN;
    if ($signed(y) > $signed(BOTTOM)) nvy -= TURN;
    ax  = nvx[31] ? -nvx : nvx;
    ay  = nvy[31] ? -nvy : nvy;
    hi  = (ax > ay) ? ax : ay;
    lo  = (ax > ay) ? ay : ax;
    spd = hi + (lo >> 1);
    len = 3;
    if (spd == 32'd0) begin
      nvx = MINS;
      nvy = 32'd0;
    end else if (spd > MAXS || spd < MINS) begin
      dvd = (spd > MAXS) ? MAXS : MINS;
      f   = 32'((64'(dvd) << 15) / 64'(spd));
      nvx = fmul(nvx, f);
      nvy = fmul(nvy, f);
      len = 36;
    end
    nx = x + nvx;
    ny = y + nvy;
  endtask

  task automatic check_all(input int i, input string what);
    check($sformatf("%s d%0d x", what, i), ox[i], m_x[i]);
    check($sformatf("%s d%0d y", what, i), oy[i], m_y[i]);
    check($sformatf("%s d%0d vx", what, i), ovx[i], m_vx[i]);
    check($sformatf("%s d%0d vy", what, i), ovy[i], m_vy[i]);
    check($sformatf("%s d%0d px", what, i), opx[i], 32'($signed(m_x[i]) >>> 15));
    check($sformatf("%s d%0d py", what, i), opy[i], 32'($signed(m_y[i]) >>> 15));
  endtask

  task automatic predict(input int i);
    model_update(m_x[i], m_y[i], m_vx[i], m_vy[i], n_x[i], n_y[i], n_vx[i], n_vy[i], m_len[i]);
    m_cnt[i] = 0;
  endtask

  // One clock: drive inputs, wait for the edge, then check whatever the model says is due.
  task automatic step(input logic r, input logic e);
    reset = r;
    en    = e;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (r) begin
        m_x[i] = ix[i]; m_y[i] = iy[i]; m_vx[i] = ivx[i]; m_vy[i] = ivy[i];
        predict(i);
        check_all(i, "reset");
      end else if (e) begin
        m_cnt[i]++;
        if (m_cnt[i] == m_len[i]) begin
          m_x[i] = n_x[i]; m_y[i] = n_y[i]; m_vx[i] = n_vx[i]; m_vy[i] = n_vy[i];
          predict(i);
          check_all(i, "update");
        end
      end
    end
  endtask

  // Hand-derived values for the first frame after reset, keyed on enabled-cycle count.
  task automatic directed_check(input int c);
    if (c == 3) begin
      check("edge vx", ovx[1], 32'h0002_1999);
      check("edge x", ox[1], 32'h001B_1999);
      check("zero vx", ovx[3], 32'h0001_8000);
      check("zero vy", ovy[3], 32'h0);
      check("zero x", ox[3], 32'h00A1_8000);
    end
    if (c == 36) begin
      check("dflt vx", ovx[0], 32'h0001_3333);
      check("dflt vy", ovy[0], 32'h0000_9999);
      check("dflt x", ox[0], 32'h00A1_3333);
      check("dflt y", oy[0], 32'h0078_9999);
      check("dflt px", opx[0], 32'd322);
      check("dflt py", opy[0], 32'd241);
      check("clamp vx", ovx[2], 32'h0003_0000);
      check("clamp x", ox[2], 32'h00A3_0000);
    end
  endtask

  initial begin
    int c;
    ix  = '{32'h00A0_0000, 32'h0019_0000, 32'h00A0_0000, 32'h00A0_0000};
    iy  = '{32'h0078_0000, 32'h0078_0000, 32'h0078_0000, 32'h0078_0000};
    ivx = '{32'h0000_8000, 32'h0002_0000, 32'h0004_0000, 32'h0};
    ivy = '{32'h0000_4000, 32'h0, 32'h0, 32'h0};

    // Plain run after a 5-cycle reset.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
    for (c = 1; c <= 36; c++) begin
      step(1'b0, 1'b1);
      directed_check(c);
    end

    // Freeze for 20 cycles in the middle of the divider.
    step(1'b1, 1'b0);
    c = 0;
    for (int k = 0; k < 10; k++) begin step(1'b0, 1'b1); c++; directed_check(c); end
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0);
    for (int k = 0; k < 60; k++) begin step(1'b0, 1'b1); c++; directed_check(c); end

    // Periodic enable: 4 high, 1 low.
    step(1'b1, 1'b0);
    c = 0;
    for (int k = 0; k < 400; k++) begin
      if (k % 5 != 4) begin
        step(1'b0, 1'b1);
        c++;
        directed_check(c);
      end else begin
        step(1'b0, 1'b0);
      end
    end

    // Reset in the middle of a division, with en high.
    step(1'b1, 1'b0);
    for (int k = 0; k < 15; k++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (c = 1; c <= 36; c++) begin
      step(1'b0, 1'b1);
      directed_check(c);
    end

    // Random enable with occasional resets.
    for (int k = 0; k < 4000; k++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
